sdram_req_sched: RTL

SDRAM_REQ_SCHED -- requirements
Module: sdram_req_sched

---
 rtl/sdram_req_sched.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_sched.sv
// -----------------------------------------------------------------------------
// sdram_req_sched
//
// Purpose:
//   Sits between a simple valid/ready user port and an SDRAM controller that
//   takes one-cycle command pulses and reports a busy flag. It keeps at most
//   one access in flight and inserts auto-refresh commands on a fixed
//   interval. A pending refresh always wins over a user request.
//
// Parameters:
//   REFRESH_CYCLES - clk cycles between refresh requests
//   ADDR_WIDTH     - word address width
//   DATA_WIDTH     - data word width
//
// Ports:
//   clk, resetn                    - clock, synchronous active-low reset
//   req_valid/req_ready            - user request handshake
//   req_we, req_addr, req_wdata    - request kind, word address, write data
//   rsp_valid, rsp_rdata           - one-cycle read strobe, held read data
//   ctl_rd, ctl_wr, ctl_refresh    - registered command pulses to controller
//   ctl_addr, ctl_din              - registered command address / write data
//   ctl_dout, ctl_data_ready       - controller read data and its strobe
//   ctl_busy                       - controller busy (registered on its side)
//   err_overrun                    - sticky refresh-overrun flag
//
// Build option:
//   SDRAM_SCHED_OVERRUN_EN - when defined, err_overrun latches whenever the
//   refresh timer expires while a refresh is still pending. When undefined
//   the flag is tied low and no detection logic is built.
// -----------------------------------------------------------------------------
module sdram_req_sched #(
    parameter int REFRESH_CYCLES = 900,
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ctl_rd,
    output logic                  ctl_wr,
    output logic                  ctl_refresh,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [DATA_WIDTH-1:0] ctl_din,
    input  logic [DATA_WIDTH-1:0] ctl_dout,
    input  logic                  ctl_data_ready,
    input  logic                  ctl_busy,
    output logic                  err_overrun
);

    localparam int TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ARM   = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  refresh_pending_q, refresh_pending_d;
    logic                  ctl_rd_q, ctl_rd_d;
    logic                  ctl_wr_q, ctl_wr_d;
    logic                  ctl_refresh_q, ctl_refresh_d;
    logic [ADDR_WIDTH-1:0] ctl_addr_q, ctl_addr_d;
    logic [DATA_WIDTH-1:0] ctl_din_q, ctl_din_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic timer_expire;
    logic refresh_start;
    logic accept;

    // The timer is free-running: it keeps counting through busy periods so
    // the refresh cadence never drifts because of long controller activity.
    assign timer_expire = (timer_q == '0);

    // A refresh can only be launched from IDLE with an idle controller; the
    // same condition gates user requests, which are additionally blocked by
    // a pending refresh so that refresh always wins. Reset forces ready low.
    assign refresh_start = (state_q == ST_IDLE) & ~ctl_busy & refresh_pending_q;
    assign req_ready     = resetn & (state_q == ST_IDLE) & ~ctl_busy & ~refresh_pending_q;
    assign accept        = req_valid & req_ready;

    // Refresh timer next state: count down, reload on reaching zero.
    always_comb begin
        timer_d = timer_q - 1'b1;
        if (timer_expire) begin
            timer_d = TIMER_RELOAD;
        end
    end

    // Pending-refresh flag. Setting wins over clearing: an expiry in the same
    // cycle that the old refresh is launched represents a new interval and
    // must stay pending. An expiry while already pending just folds into the
    // single pending slot.
    always_comb begin
        refresh_pending_d = refresh_pending_q;
        if (timer_expire) begin
            refresh_pending_d = 1'b1;
        end else if (refresh_start) begin
            refresh_pending_d = 1'b0;
        end
    end

    // Main sequencer. Commands are computed here and registered, so a command
    // pulse is visible exactly during the ISSUE state. ARM gives the
    // controller one cycle to raise its registered busy before WAIT looks at
    // it, otherwise WAIT would see the stale idle value and return too early.
    always_comb begin
        state_d       = state_q;
        ctl_rd_d      = 1'b0;
        ctl_wr_d      = 1'b0;
        ctl_refresh_d = 1'b0;
        ctl_addr_d    = ctl_addr_q;
        ctl_din_d     = ctl_din_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh_start) begin
                    state_d       = ST_ISSUE;
                    ctl_refresh_d = 1'b1;
                end else if (accept) begin
                    state_d    = ST_ISSUE;
                    ctl_addr_d = req_addr;
                    ctl_din_d  = req_wdata;
                    ctl_wr_d   = req_we;
                    ctl_rd_d   = ~req_we;
                end
            end
            ST_ISSUE: state_d = ST_ARM;
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (!ctl_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read response path: the controller strobe is simply delayed by one
    // register stage, and the data register only moves on a strobe so that
    // rsp_rdata holds the last read value.
    always_comb begin
        rsp_valid_d = ctl_data_ready;
        rsp_rdata_d = rsp_rdata_q;
        if (ctl_data_ready) begin
            rsp_rdata_d = ctl_dout;
        end
    end

    // State register bank. Reset is synchronous and takes effect in any
    // state, which also kills any command that would otherwise be issued.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q           <= ST_IDLE;
            timer_q           <= TIMER_RELOAD;
            refresh_pending_q <= 1'b0;
            ctl_rd_q          <= 1'b0;
            ctl_wr_q          <= 1'b0;
            ctl_refresh_q     <= 1'b0;
            ctl_addr_q        <= '0;
            ctl_din_q         <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_rdata_q       <= '0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            refresh_pending_q <= refresh_pending_d;
            ctl_rd_q          <= ctl_rd_d;
            ctl_wr_q          <= ctl_wr_d;
            ctl_refresh_q     <= ctl_refresh_d;
            ctl_addr_q        <= ctl_addr_d;
            ctl_din_q         <= ctl_din_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_rdata_q       <= rsp_rdata_d;
        end
    end

`ifdef SDRAM_SCHED_OVERRUN_EN
    logic err_overrun_q, err_overrun_d;

    // Overrun means a whole refresh interval elapsed without the previous
    // refresh being serviced; the flag is sticky until reset.
    always_comb begin
        err_overrun_d = err_overrun_q | (timer_expire & refresh_pending_q);
    end

    // Sticky overrun register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_overrun_q <= 1'b0;
        end else begin
            err_overrun_q <= err_overrun_d;
        end
    end

    assign err_overrun = err_overrun_q;
`else
    assign err_overrun = 1'b0;
`endif

    assign ctl_rd      = ctl_rd_q;
    assign ctl_wr      = ctl_wr_q;
    assign ctl_refresh = ctl_refresh_q;
    assign ctl_addr    = ctl_addr_q;
    assign ctl_din     = ctl_din_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule
